uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter. It is the transmit end of the serial link whose receive end is the testbench UART monitor. It drives the Caravel UART RX pad (mprj_io[5]) from bench or user-project logic, so firmware receive paths can be exercised. Bytes are accepted through a valid/ready handshake into a small FIFO and serialized LSB-first at a fixed bit period.

Parameters:
CLKS_PER_BIT, 4167, clock cycles per serial bit (40 MHz / 9600 baud); legal range is 2 or more.
FIFO_DEPTH, 8, byte entries in the transmit FIFO; must be a power of 2, 2 or more.

Ports:
clock  input  1  single system clock, rising-edge.
resetb  input  1  asynchronous active-low reset.
in_data  input  8  byte to transmit.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  FIFO can accept a byte (registered, equals not-full).
ser_tx  output  1  serial line; idles high.
busy  output  1  a frame is in progress, or the FIFO is non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetb low, asynchronous):
  - ser_tx=1, in_ready=1, busy=0, fifo_count=0.
  - FSM goes to IDLE; bit and baud counters clear; FIFO pointers clear.
  - Reset asserted mid-frame aborts the frame and forces ser_tx high immediately. The partial frame is not resumed.
- Push: in_valid and in_ready both high at a rising edge writes in_data. in_valid while in_ready is low is ignored (no write, no error flag). The source must hold the byte.
- in_ready is registered. A pop in the same cycle as a push attempt while full does not admit the push; in_ready rises the cycle after the pop.
- Simultaneous push and pop (not full, not empty): fifo_count is unchanged and both operations take effect.
- FSM states:
  - IDLE: ser_tx=1. If the FIFO is non-empty at an edge, pop the head into the shift register, drive ser_tx=0, clear the baud counter, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then output data bit 0 and go to DATA.
  - DATA: output each bit for CLKS_PER_BIT cycles, LSB first. After bit 7 completes, drive 1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. On completion, if the FIFO is non-empty, pop and drive 0 and go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit index is 3 bits and counts 0..7.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE drives ser_tx low after edge N+1.
- ser_tx is a flop output (glitch-free).
- busy = (state != IDLE) or (fifo_count != 0).
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count saturates naturally at FIFO_DEPTH and never exceeds it.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant.
- One sub-module: sync_fifo, parameterized by width and depth.
  - Ports: clock, resetb, wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - rd_data is first-word-fall-through (head visible while not empty).
- The top level holds the FSM, baud counter, bit counter and shift register.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset, then push 0x55 once -> ser_tx falls the cycle after the push. Sampled per 4-cycle bit, it reads 0,1,0,1,0,1,0,1,0,1. The frame is 40 cycles, then idle high; busy deasserts after the stop bit.
2. Push 0xA3, 0x0F back-to-back -> the bench UART receiver decodes 0xA3 then 0x0F. The second start bit begins on the cycle immediately after the first stop bit ends (80 contiguous cycles).
3. Hold in_valid for 6 cycles with bytes 0x01..0x06 while idle -> bytes 0x01 to 0x05 are accepted (one popped, four queued). in_ready drops, 0x06 is refused, and fifo_count peaks at 4. The serial output carries 0x01..0x05 in order.
4. Full FIFO, hold in_valid with 0x77 -> in_ready rises one cycle after the pop at the first stop-bit end, 0x77 is accepted that cycle, and fifo_count returns to 4.
5. Assert resetb low mid-DATA of 0xC4 -> ser_tx=1, busy=0 and fifo_count=0 within the same timestep. After release, a push of 0x3C transmits correctly.
6. in_valid=1 with in_ready=0 and in_data changing every cycle -> none of those values appear on ser_tx.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared constants for the buffered UART transmitter.
//   - FSM state encoding (legacy-compatible 2-bit localparams).
//   - Frame geometry (data bits per frame).
//   - Default bit period: 40 MHz system clock at 9600 baud.
// ----------------------------------------------------------------------------
package uart_pkg;

    // Transmit FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // 8N1 framing: 8 data bits, no parity, 1 stop bit
    localparam int unsigned UART_DATA_BITS = 8;

    // 40_000_000 / 9600, rounded
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 4167;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with first-word-fall-through read data.
//   full/empty are flops computed from the next occupancy, so they are clean
//   registered flags; a pop does not free a slot for a push until the next
//   cycle.
//
// Ports
//   clock    in   rising-edge clock
//   resetb   in   asynchronous active-low reset
//   wr_en    in   write wr_data (ignored while full)
//   wr_data  in   WIDTH-bit write data
//   rd_en    in   pop the head entry (ignored while empty)
//   rd_data  out  head entry, valid while not empty
//   full     out  occupancy == DEPTH (registered)
//   empty    out  occupancy == 0 (registered)
//   count    out  current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    logic wr_fire;
    logic rd_fire;

    assign wr_fire = wr_en & ~full_q;
    assign rd_fire = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // DEPTH is a power of two, so pointers wrap by natural overflow
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes enter a small FIFO through a
//   valid/ready handshake and are serialized LSB-first, one bit every
//   CLKS_PER_BIT clocks. Consecutive bytes are sent back-to-back with no idle
//   gap between the stop bit and the next start bit.
//
// Ports
//   clock       in   rising-edge system clock
//   resetb      in   asynchronous active-low reset (aborts any frame)
//   in_data     in   byte to transmit
//   in_valid    in   in_data is valid this cycle
//   in_ready    out  FIFO can accept a byte (registered not-full)
//   ser_tx      out  serial line, idles high, driven from a flop
//   busy        out  frame in progress or FIFO non-empty
//   fifo_count  out  current FIFO occupancy
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic [1:0]                state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;

    logic                      fifo_wr;
    logic                      fifo_pop;
    logic [7:0]                fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      baud_end;

    assign in_ready = ~fifo_full;
    assign fifo_wr  = in_valid & in_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end

            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift right so the next bit always sits at [0]
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        tx_d     = 1'b0;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign ser_tx = tx_q;
    assign busy   = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clock    = 1'b0;
    logic       resetb   = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ser_tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Expected line level for bit slot j (0=start, 1..8 data LSB first, 9=stop)
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Bench UART receiver: find a start bit, then sample mid-bit
    task automatic rx_byte(output logic [7:0] b, output logic stop_bit,
                           output logic timed_out);
        int w;
        w = 0;
        b = 8'h00;
        stop_bit = 1'b0;
        timed_out = 1'b0;
        @(negedge clock);
        while (ser_tx !== 1'b0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (ser_tx !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = ser_tx;
        end
        repeat (CPB) @(negedge clock);
        stop_bit = ser_tx;
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetb = 1'b0;
        #1;
        checks++;
        if (ser_tx !== 1'b1) begin
            failures++; $display("FAIL reset_ser_tx got=%b exp=1", ser_tx);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count);
        end
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (ser_tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got ser_tx=%b busy=%b exp ser_tx=1 busy=0",
                     ser_tx, busy);
        end
    endtask

    task automatic test_single_frame();
        @(negedge clock);
        in_data  = 8'h55;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (ser_tx !== 1'b1 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL push_latency got ser_tx=%b count=%0d exp ser_tx=1 count=1",
                     ser_tx, fifo_count);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            checks++;
            if (ser_tx !== frame_bit(8'h55, k / CPB)) begin
                failures++;
                $display("FAIL frame55 cycle=%0d got=%b exp=%b", k, ser_tx,
                         frame_bit(8'h55, k / CPB));
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL frame55_busy cycle=%0d got=%b exp=1", k, busy);
            end
            if (k == 0) begin
                checks++;
                if (fifo_count !== 3'd0) begin
                    failures++; $display("FAIL frame55_pop got=%0d exp=0", fifo_count);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (ser_tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL frame55_end got ser_tx=%b busy=%b exp ser_tx=1 busy=0",
                     ser_tx, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        @(negedge clock);
        in_data  = 8'hA3;
        in_valid = 1'b1;
        @(negedge clock);
        in_data  = 8'h0F;
        @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1) begin
            failures++; $display("FAIL b2b_push_pop_count got=%0d exp=1", fifo_count);
        end
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clock);
            b = (k < 40) ? 8'hA3 : 8'h0F;
            checks++;
            if (ser_tx !== frame_bit(b, (k % 40) / CPB)) begin
                failures++;
                $display("FAIL b2b cycle=%0d got=%b exp=%b", k, ser_tx,
                         frame_bit(b, (k % 40) / CPB));
            end
        end
        @(negedge clock);
        checks++;
        if (ser_tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got ser_tx=%b busy=%b exp ser_tx=1 busy=0", ser_tx, busy);
        end
    endtask

    task automatic test_fill_refuse();
        logic [7:0] got [5];
        logic       sb  [5];
        logic       to  [5];
        int         peak;
        logic       saw_low;
        peak = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    in_data  = 8'(i);
                    in_valid = 1'b1;
                    if (i == 5) begin
                        checks++;
                        if (in_ready !== 1'b1) begin
                            failures++; $display("FAIL fill_ready5 got=%b exp=1", in_ready);
                        end
                    end
                    if (i == 6) begin
                        checks++;
                        if (in_ready !== 1'b0) begin
                            failures++; $display("FAIL fill_ready6 got=%b exp=0", in_ready);
                        end
                    end
                    @(negedge clock);
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                end
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 5; n++) begin
                    rx_byte(got[n], sb[n], to[n]);
                end
            end
        join
        checks++;
        if (peak != 4) begin
            failures++; $display("FAIL fill_peak got=%0d exp=4", peak);
        end
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (to[n] !== 1'b0 || got[n] !== 8'(n + 1) || sb[n] !== 1'b1) begin
                failures++;
                $display("FAIL fill_rx%0d got=%h stop=%b timeout=%b exp=%h stop=1 timeout=0",
                         n, got[n], sb[n], to[n], 8'(n + 1));
            end
        end
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (ser_tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL fill_refused_byte got low=%b busy=%b count=%0d exp low=0 busy=0 count=0",
                     saw_low, busy, fifo_count);
        end
    endtask

    task automatic test_full_pop();
        logic early_ready;
        int   w;
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'h11 + 8'(i);
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_data  = 8'h77;
        in_valid = 1'b1;
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_start got count=%0d ready=%b exp count=4 ready=0",
                     fifo_count, in_ready);
        end
        early_ready = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clock);
            if (k < 37 && in_ready !== 1'b0) early_ready = 1'b1;
            if (k == 37) begin
                checks++;
                if (in_ready !== 1'b1 || fifo_count !== 3'd3) begin
                    failures++;
                    $display("FAIL full_after_pop got ready=%b count=%0d exp ready=1 count=3",
                             in_ready, fifo_count);
                end
            end
            if (k == 38) begin
                checks++;
                if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
                    failures++;
                    $display("FAIL full_accept77 got ready=%b count=%0d exp ready=0 count=4",
                             in_ready, fifo_count);
                end
                in_valid = 1'b0;
            end
        end
        checks++;
        if (early_ready !== 1'b0) begin
            failures++; $display("FAIL full_early_ready got=%b exp=0", early_ready);
        end
        w = 0;
        while (busy !== 1'b0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || ser_tx !== 1'b1) begin
            failures++;
            $display("FAIL full_drain got busy=%b count=%0d ser_tx=%b exp busy=0 count=0 ser_tx=1",
                     busy, fifo_count, ser_tx);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_low;
        @(negedge clock);
        in_data  = 8'hC4;
        in_valid = 1'b1;
        @(negedge clock);
        in_data  = 8'h99;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        // Data bit 0 of 0xC4 is 0, so the line is low right before reset
        checks++;
        if (ser_tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL mid_pre got ser_tx=%b busy=%b count=%0d exp ser_tx=0 busy=1 count=1",
                     ser_tx, busy, fifo_count);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if (ser_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got ser_tx=%b busy=%b count=%0d ready=%b exp 1 0 0 1",
                     ser_tx, busy, fifo_count, in_ready);
        end
        @(negedge clock);
        resetb = 1'b1;
        saw_low = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (ser_tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0) begin
            failures++; $display("FAIL mid_no_resume got activity=%b exp=0", saw_low);
        end
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            checks++;
            if (ser_tx !== frame_bit(8'h3C, k / CPB)) begin
                failures++;
                $display("FAIL frame3c cycle=%0d got=%b exp=%b", k, ser_tx,
                         frame_bit(8'h3C, k / CPB));
            end
        end
        @(negedge clock);
        checks++;
        if (ser_tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL frame3c_end got ser_tx=%b busy=%b exp ser_tx=1 busy=0", ser_tx, busy);
        end
    endtask

    task automatic test_refused_data();
        logic [7:0] exp_b [5];
        logic [7:0] got   [5];
        logic       sb    [5];
        logic       to    [5];
        logic       done;
        logic       saw_low;
        int         n;
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    in_data  = exp_b[i];
                    in_valid = 1'b1;
                    @(negedge clock);
                end
                n = 0;
                // Offer a new byte every cycle, but only while in_ready is low
                while (!done) begin
                    if (in_ready === 1'b1) begin
                        in_valid = 1'b0;
                    end else begin
                        in_valid = 1'b1;
                        in_data  = 8'h40 + 8'(n);
                        n++;
                    end
                    @(negedge clock);
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    rx_byte(got[j], sb[j], to[j]);
                end
                done = 1'b1;
            end
        join
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (to[j] !== 1'b0 || got[j] !== exp_b[j] || sb[j] !== 1'b1) begin
                failures++;
                $display("FAIL refused_rx%0d got=%h stop=%b timeout=%b exp=%h stop=1 timeout=0",
                         j, got[j], sb[j], to[j], exp_b[j]);
            end
        end
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (ser_tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL refused_leak got low=%b busy=%b count=%0d exp low=0 busy=0 count=0",
                     saw_low, busy, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fill_refuse();
        test_full_pop();
        test_reset_mid();
        test_refused_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
